adaptiveavgpool1d_stream_ctrl: RTL and testbench
================================================

# adaptiveavgpool1d_stream_ctrl

Sequential controller for 1-D adaptive average pooling over a serial stream. It accepts one input element per handshake and tracks the PyTorch-style adaptive window boundaries for each row of `DATA_IN_0_TENSOR_SIZE_DIM_0` elements. It accumulates each window, divides by the window length with a shared iterative divider, and emits one output element per window. It replaces the combinational pooling datapath wherever inputs arrive one beat at a time and window sizes are not uniform.

## Interface
- `DATA_IN_0_PRECISION_0`, 8, input element width (signed fixed point).
- `DATA_IN_0_PRECISION_1`, 3, fractional bits. Passed through unchanged.
- `DATA_IN_0_TENSOR_SIZE_DIM_0`, 8, row length L.
- `DATA_IN_0_TENSOR_SIZE_DIM_1`, 1, rows per tensor. Rows are processed back-to-back and independently.
- `DATA_OUT_0_PRECISION_0`, 8, must equal `DATA_IN_0_PRECISION_0`. Elaboration `$error` otherwise.
- `DATA_OUT_0_PRECISION_1`, 3, must equal `DATA_IN_0_PRECISION_1`.
- `DATA_OUT_0_TENSOR_SIZE_DIM_0`, 4, output length O. Requires 1 ≤ O ≤ L, checked with `$error`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `data_in_0`  in  `DATA_IN_0_PRECISION_0`  input element (parallelism fixed at 1).
- `data_in_0_valid`  in  1  input valid.
- `data_in_0_ready`  out  1  input ready.
- `data_out_0`  out  `DATA_OUT_0_PRECISION_0`  window average.
- `data_out_0_valid`  out  1  output valid.
- `data_out_0_ready`  in  1  output ready.

## Operation
- **Window boundaries.** For window i: start(i) = floor(i·L/O) and end(i) = ceil((i+1)·L/O), exclusive. Length is end − start.
- **Overlap.** Consecutive windows overlap by 0 or 1 element. An element can belong to at most two windows.
- **Counters.**
  - `elem_idx` runs 0..L−1 and wraps to 0 after L−1.
  - `win_idx` runs 0..O−1 and wraps with it.
- **Boundary tables.** Start, end and length per window come from elaboration-time constant arrays. No runtime multipliers.
- **FSM states:** ACCUM, DIVIDE, OUTPUT.
- **ACCUM.** On an accepted element x:
  - If x does not close window i: `acc += x`.
  - If `elem_idx == end(i)−1`: latch `acc + x` into the divider. Latch the divisor `len(i)`. Go to DIVIDE.
  - Next accumulator: if `start(i+1) == elem_idx` (overlap), `acc` is seeded with x; otherwise `acc` = 0.
- **DIVIDE.** Signed sum divided by unsigned length, truncated toward zero (divide the magnitude, then restore the sign).
  - Takes exactly ACC_W cycles, where ACC_W = `DATA_IN_0_PRECISION_0` + clog2(ceil(L/O)+1).
  - On done: the quotient's low `DATA_OUT_0_PRECISION_0` bits (always in range) go to the `data_out_0` register. Go to OUTPUT.
- **OUTPUT.** `data_out_0_valid` is 1. On `data_out_0_ready`, go to ACCUM and advance `win_idx`.
- **Ready.** `data_in_0_ready` = (state == ACCUM) and not in reset. No input is accepted during DIVIDE or OUTPUT.
- **Arithmetic.** Accumulator is signed, ACC_W bits wide, and never overflows by construction.

## Timing
- **Reset values:**
  - state = ACCUM
  - `acc` = 0
  - `elem_idx` = 0, `win_idx` = 0
  - `data_out_0` = 0
  - `data_out_0_valid` = 0
  - `data_in_0_ready` = 0 while `rst` is high, 1 from the first cycle after deassertion.
- **Latency.** With the closing element's handshake in cycle t, `data_out_0_valid` rises in cycle t+ACC_W+1.
- **Backpressure.**
  - Output is held stable while `data_out_0_valid && !data_out_0_ready`.
  - After the output handshake in cycle u, `data_in_0_ready` is 1 in cycle u+1.
- **No combinational paths.** There is no combinational path from `data_out_0_ready` to `data_in_0_ready`, or from `data_in_0_valid` to `data_out_0_valid`.
- **Row boundary.** Element L−1 always closes window O−1. The next row starts with `acc` = 0 and no carry.
- **Reset mid-operation.** An asynchronous `rst` in any state discards the partial sum and any pending divide or output. The next row starts at element 0.
- **Valid without ready.** `data_in_0_valid` asserted while ready is low is ignored. The upstream source holds the data.

## Structure
- **Shared package `pooling_pkg`:**
  - FSM state enum `pool_ctrl_state_t` (ACCUM, DIVIDE, OUTPUT).
  - Constant functions `adaptive_start(i,L,O)`, `adaptive_end(i,L,O)` and `acc_width(P,L,O)`.
- **Sub-module `pool_serial_div`:** iterative restoring signed/unsigned divider.
  - Ports: start/busy/done handshake, dividend ACC_W bits, divisor clog2 width, quotient out.
  - One quotient bit per cycle.
- **Top level:** counters, boundary tables, accumulator, FSM and output register.

## Test plan
- **L=8, O=4.** Raw inputs 1..8, ready always high → outputs 1, 3, 5, 7. Each output rises exactly ACC_W+1 cycles after the 2nd, 4th, 6th and 8th accept.
- **L=5, O=3, overlap.** Inputs 10, 20, 30, 40, 50 → outputs 15, 30, 45. Elements 1 and 3 each count in two windows.
- **Negative truncation.** L=2, O=1, inputs −3, −4 → output −3 (toward zero, not −4).
- **Backpressure.** `data_out_0_ready` held low 10 cycles on the first output → `data_out_0` and valid stable, `data_in_0_ready` 0 throughout, and the second row result is still correct.
- **Identity.** L=O=4, inputs −8, 0, 7, 127 → identical outputs, one per ACC_W+2-cycle handshake loop.
- **Reset mid-DIVIDE.** Assert `rst` asynchronously during DIVIDE → valid and ready drop to 0 immediately. After release, inputs 2, 4, … give clean first-row results with no stale sum.

Source files
------------

// File: rtl/pooling_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pooling_pkg
// Description : Shared types and elaboration-time helpers for the serial
//               adaptive average pooling controller.
//               - pool_ctrl_state_t : controller FSM state encoding
//               - adaptive_start    : first element index of window i
//               - adaptive_end      : exclusive end index of window i
//               - max_window        : upper bound on any window length
//               - acc_width         : accumulator width that cannot overflow
//               - safe_width        : $clog2 that never returns zero
// Revision    : 1.0 - initial release
// ============================================================================
package pooling_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } pool_ctrl_state_t;

    // floor(i*L/O)
    function automatic int adaptive_start(input int i, input int l, input int o);
        return (i * l) / o;
    endfunction

    // ceil((i+1)*L/O), exclusive
    function automatic int adaptive_end(input int i, input int l, input int o);
        return ((i + 1) * l + o - 1) / o;
    endfunction

    // Adjacent windows overlap by at most one element, so no window is
    // longer than ceil(L/O) + 1.
    function automatic int max_window(input int l, input int o);
        return (l + o - 1) / o + 1;
    endfunction

    function automatic int acc_width(input int p, input int l, input int o);
        return p + $clog2(max_window(l, o));
    endfunction

    function automatic int safe_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_serial_div.sv
`default_nettype none
// ============================================================================
// Module      : pool_serial_div
// Description : Iterative restoring divider, signed dividend by unsigned
//               divisor, truncating toward zero. The magnitude is divided one
//               quotient bit per cycle and the sign is restored on the way out.
//               A division takes exactly ACC_W cycles after the start cycle.
//               done is asserted combinationally in the last iteration cycle,
//               together with a valid quotient.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               start         - load operands (ignored while busy)
//               dividend      - ACC_W-bit two's complement dividend
//               divisor       - DIV_W-bit unsigned divisor (non-zero)
//               busy          - iteration in progress
//               done          - final iteration cycle, quotient valid
//               quotient      - low Q_W bits of the signed quotient
// Revision    : 1.0 - initial release
// ============================================================================
module pool_serial_div
    import pooling_pkg::*;
#(
    parameter int ACC_W = 10,
    parameter int DIV_W = 2,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int c_CNT_W = safe_width(ACC_W);

    if (Q_W < 2 || Q_W > ACC_W - 1) begin : g_chk_qw
        $error("pool_serial_div: Q_W must lie in [2, ACC_W-1]");
    end

    // r_dvd holds the remaining dividend magnitude bits in its upper part and
    // the quotient bits produced so far in its lower part.
    logic [ACC_W-1:0]   r_dvd;
    logic [DIV_W-1:0]   r_dvs;
    logic [DIV_W-1:0]   r_rem;
    logic               r_neg;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;

    logic [DIV_W:0]     w_trial;
    logic               w_ge;
    logic [DIV_W-1:0]   w_diff;
    logic [DIV_W-1:0]   w_rem_next;
    logic [Q_W-1:0]     w_q_low;

    assign w_trial    = {r_rem, r_dvd[ACC_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_dvs});
    // When w_ge holds, the true difference is below the divisor and fits in
    // DIV_W bits, so the modular subtraction is exact.
    assign w_diff     = w_trial[DIV_W-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_diff : w_trial[DIV_W-1:0];

    assign busy       = r_busy;
    assign done       = r_busy && (r_cnt == c_CNT_W'(ACC_W - 1));
    assign w_q_low    = {r_dvd[Q_W-2:0], w_ge};
    assign quotient   = r_neg ? (~w_q_low + Q_W'(1)) : w_q_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start && !r_busy) begin
            r_dvd  <= dividend[ACC_W-1] ? (~dividend + ACC_W'(1)) : dividend;
            r_neg  <= dividend[ACC_W-1];
            r_dvs  <= divisor;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_dvd <= {r_dvd[ACC_W-2:0], w_ge};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adaptiveavgpool1d_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adaptiveavgpool1d_stream_ctrl
// Description : Serial 1-D adaptive average pooling. Accepts one element per
//               handshake, accumulates each adaptive window, divides the sum
//               by the window length with a shared iterative divider and
//               emits one element per window. Rows of L elements are
//               processed back-to-back and independently.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               data_in_0         - input element (signed fixed point)
//               data_in_0_valid   - input valid
//               data_in_0_ready   - input ready (only in ACCUM)
//               data_out_0        - window average
//               data_out_0_valid  - output valid (only in OUTPUT)
//               data_out_0_ready  - output ready
// Revision    : 1.0 - initial release
// ============================================================================
module adaptiveavgpool1d_stream_ctrl
    import pooling_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int c_P     = DATA_IN_0_PRECISION_0;
    localparam int c_L     = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int c_O     = DATA_OUT_0_TENSOR_SIZE_DIM_0;
    localparam int c_ACC_W = acc_width(c_P, c_L, c_O);
    localparam int c_DIV_W = safe_width(max_window(c_L, c_O) + 1);
    localparam int c_IDX_W = safe_width(c_L);
    localparam int c_WIN_W = safe_width(c_O);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) begin : g_chk_prec0
        $error("DATA_OUT_0_PRECISION_0 must equal DATA_IN_0_PRECISION_0");
    end
    if (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_chk_prec1
        $error("DATA_OUT_0_PRECISION_1 must equal DATA_IN_0_PRECISION_1");
    end
    if (c_O < 1 || c_O > c_L) begin : g_chk_len
        $error("DATA_OUT_0_TENSOR_SIZE_DIM_0 must lie in [1, DATA_IN_0_TENSOR_SIZE_DIM_0]");
    end
    if (DATA_IN_0_TENSOR_SIZE_DIM_1 < 1) begin : g_chk_rows
        $error("DATA_IN_0_TENSOR_SIZE_DIM_1 must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Window boundary tables (constants, no runtime arithmetic)
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_tab_start [c_O];
    logic [c_IDX_W-1:0] w_tab_last  [c_O];
    logic [c_DIV_W-1:0] w_tab_len   [c_O];

    for (genvar gi = 0; gi < c_O; gi++) begin : g_tab
        assign w_tab_start[gi] = c_IDX_W'(adaptive_start(gi, c_L, c_O));
        assign w_tab_last[gi]  = c_IDX_W'(adaptive_end(gi, c_L, c_O) - 1);
        assign w_tab_len[gi]   = c_DIV_W'(adaptive_end(gi, c_L, c_O)
                                          - adaptive_start(gi, c_L, c_O));
    end

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    pool_ctrl_state_t   r_state;
    pool_ctrl_state_t   w_state_next;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_IDX_W-1:0] r_elem_idx;
    logic [c_WIN_W-1:0] r_win_idx;
    logic [c_P-1:0]     r_data_out;

    logic [c_ACC_W-1:0] w_x_ext;
    logic [c_ACC_W-1:0] w_sum;
    logic [c_IDX_W-1:0] w_elem_next;
    logic [c_WIN_W-1:0] w_win_next;
    logic               w_last_win;
    logic               w_accept;
    logic               w_close;
    logic               w_seed;
    logic               w_out_fire;
    logic               w_in_ready_st;
    logic               w_out_valid_st;

    logic               w_div_start;
    logic               w_div_busy;
    logic               w_div_done;
    logic [c_P-1:0]     w_div_quot;

    // ------------------------------------------------------------------------
    // Handshakes and window tracking
    // ------------------------------------------------------------------------
    assign w_in_ready_st    = (r_state == ACCUM);
    assign w_out_valid_st   = (r_state == OUTPUT);

    assign data_in_0_ready  = w_in_ready_st && !w_div_busy && !rst;
    assign data_out_0_valid = w_out_valid_st;
    assign data_out_0       = r_data_out;

    assign w_accept   = data_in_0_valid && data_in_0_ready;
    assign w_out_fire = data_out_0_valid && data_out_0_ready;

    assign w_x_ext    = {{(c_ACC_W - c_P){data_in_0[c_P-1]}}, data_in_0};
    assign w_sum      = r_acc + w_x_ext;

    assign w_last_win  = (r_win_idx == c_WIN_W'(c_O - 1));
    assign w_win_next  = w_last_win ? '0 : r_win_idx + c_WIN_W'(1);
    assign w_elem_next = (r_elem_idx == c_IDX_W'(c_L - 1)) ? '0
                                                           : r_elem_idx + c_IDX_W'(1);

    assign w_close     = (r_elem_idx == w_tab_last[r_win_idx]);
    assign w_div_start = w_accept && w_close;

    // The closing element also opens the next window when the windows
    // overlap. The last window of a row never seeds: the next row is fresh.
    assign w_seed = !w_last_win && (w_tab_start[w_win_next] == r_elem_idx);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: begin
                if (w_div_start) begin
                    w_state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    w_state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (data_out_0_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: counters, accumulator and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_elem_idx <= '0;
            r_win_idx  <= '0;
            r_data_out <= '0;
        end else begin
            if (w_accept) begin
                r_elem_idx <= w_elem_next;
                if (w_close) begin
                    r_acc <= w_seed ? w_x_ext : '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
            if ((r_state == DIVIDE) && w_div_done) begin
                r_data_out <= w_div_quot;
            end
            if (w_out_fire) begin
                r_win_idx <= w_win_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shared divider
    // ------------------------------------------------------------------------
    pool_serial_div #(
        .ACC_W (c_ACC_W),
        .DIV_W (c_DIV_W),
        .Q_W   (c_P)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_sum),
        .divisor  (w_tab_len[r_win_idx]),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_div_quot)
    );

endmodule
`default_nettype wire

// File: tb/tb_adaptiveavgpool1d_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adaptiveavgpool1d_stream_ctrl
// Description : Scoreboard bench. Four controller instances with different
//               row/output lengths are exercised one after another; expected
//               averages and rise cycles are queued at stimulus time and a
//               negedge monitor checks every output as it appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adaptiveavgpool1d_stream_ctrl;

    localparam int c_N = 4;
    localparam int c_LS   [c_N] = '{8, 5, 2, 4};
    localparam int c_OS   [c_N] = '{4, 3, 1, 4};
    localparam int c_RS   [c_N] = '{2, 1, 1, 1};
    // P + clog2(ceil(L/O)+1), worked out by hand per instance
    localparam int c_ACCW [c_N] = '{10, 10, 10, 9};

    typedef struct {
        int inst;
        int val;
        int rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din        [c_N];
    logic       din_valid  [c_N];
    logic       din_ready  [c_N];
    logic [7:0] dout       [c_N];
    logic       dout_valid [c_N];
    logic       dout_ready [c_N];
    logic       prev_v     [c_N] = '{1'b0, 1'b0, 1'b0, 1'b0};

    exp_t exp_q [$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < c_N; k++) begin : g_dut
        adaptiveavgpool1d_stream_ctrl #(
            .DATA_IN_0_PRECISION_0        (8),
            .DATA_IN_0_PRECISION_1        (3),
            .DATA_IN_0_TENSOR_SIZE_DIM_0  (c_LS[k]),
            .DATA_IN_0_TENSOR_SIZE_DIM_1  (c_RS[k]),
            .DATA_OUT_0_PRECISION_0       (8),
            .DATA_OUT_0_PRECISION_1       (3),
            .DATA_OUT_0_TENSOR_SIZE_DIM_0 (c_OS[k])
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .data_in_0        (din[k]),
            .data_in_0_valid  (din_valid[k]),
            .data_in_0_ready  (din_ready[k]),
            .data_out_0       (dout[k]),
            .data_out_0_valid (dout_valid[k]),
            .data_out_0_ready (dout_ready[k])
        );
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Present one element and wait for its handshake. A closing element
    // queues the expected average and the cycle its valid must rise.
    task automatic send(input int k, input int x, input bit closes, input int expv,
                        output int acc_cyc);
        int   n;
        exp_t e;
        n = 0;
        din[k]       = 8'(x);
        din_valid[k] = 1'b1;
        @(negedge clk);
        while (!din_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        if (!din_ready[k]) begin
            check("accept_timeout", 0, 1);
        end else if (closes) begin
            e.inst = k;
            e.val  = expv;
            e.rise = cyc + c_ACCW[k] + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        din_valid[k] = 1'b0;
    endtask

    task automatic send_row(input int k, input int n, input int xs [8],
                            input logic [7:0] cm, input int ex [8]);
        int j;
        int a;
        j = 0;
        for (int i = 0; i < n; i++) begin
            send(k, xs[i], cm[i], ex[j], a);
            if (cm[i]) j++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising output valid is matched against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < c_N; k++) begin
            if (dout_valid[k] && !prev_v[k]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_inst", k, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_inst", k, mon_e.inst);
                    check("out_value", int'($signed(dout[k])), mon_e.val);
                    check("out_latency", cyc, mon_e.rise);
                end
            end
            prev_v[k] = dout_valid[k];
        end
    end

    initial begin
        int   xs   [8];
        int   ex   [8];
        int   idv  [4];
        int   acyc [4];
        int   a;
        int   n;
        bit   bp_ok;

        rst = 1'b1;
        for (int k = 0; k < c_N; k++) begin
            din[k]        = '0;
            din_valid[k]  = 1'b0;
            dout_ready[k] = 1'b1;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            check("rst_in_ready", din_ready[k], 0);
            check("rst_out_valid", dout_valid[k], 0);
            check("rst_out_data", dout[k], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < c_N; k++) begin
            check("ready_after_rst", din_ready[k], 1);
        end
        @(posedge clk);
        #1;

        // L=8, O=4: windows {0,1} {2,3} {4,5} {6,7}
        xs = '{1, 2, 3, 4, 5, 6, 7, 8};
        ex = '{1, 3, 5, 7, 0, 0, 0, 0};
        send_row(0, 8, xs, 8'b1010_1010, ex);
        drain("drain_l8o4");

        // L=5, O=3: windows {0,1} {1,2,3} {3,4}
        xs = '{10, 20, 30, 40, 50, 0, 0, 0};
        ex = '{15, 30, 45, 0, 0, 0, 0, 0};
        send_row(1, 5, xs, 8'b0001_1010, ex);
        drain("drain_overlap");

        // L=2, O=1: -7/2 truncates to -3
        xs = '{-3, -4, 0, 0, 0, 0, 0, 0};
        ex = '{-3, 0, 0, 0, 0, 0, 0, 0};
        send_row(2, 2, xs, 8'b0000_0010, ex);
        drain("drain_negative");

        // L=O=4: identity, one accept every ACC_W+2 = 11 cycles
        idv = '{-8, 0, 7, 127};
        for (int i = 0; i < 4; i++) begin
            send(3, idv[i], 1'b1, idv[i], acyc[i]);
        end
        for (int i = 1; i < 4; i++) begin
            check("identity_loop_cycles", acyc[i] - acyc[i-1], 11);
        end
        drain("drain_identity");

        // Second row on the L=8 instance with the first output stalled
        dout_ready[0] = 1'b0;
        xs = '{10, -20, 30, 40, -50, 60, 7, 8};
        ex = '{-5, 35, 5, 7, 0, 0, 0, 0};
        fork
            send_row(0, 8, xs, 8'b1010_1010, ex);
            begin
                n = 0;
                @(negedge clk);
                while (!dout_valid[0] && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                bp_ok = dout_valid[0];
                for (int i = 0; i < 10; i++) begin
                    if (!dout_valid[0] || dout[0] != 8'hFB || din_ready[0]) bp_ok = 1'b0;
                    @(negedge clk);
                end
                check("backpressure_stable", bp_ok, 1);
                @(posedge clk);
                #1 dout_ready[0] = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset in the middle of a divide
        send(0, 2, 1'b0, 0, a);
        send(0, 4, 1'b0, 0, a);
        repeat (3) @(negedge clk);
        check("divide_in_ready", din_ready[0], 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", dout_valid[0], 0);
        check("midrst_in_ready", din_ready[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", din_ready[0], 1);
        @(posedge clk);
        #1;
        xs = '{2, 4, 6, 8, 10, 12, 14, 16};
        ex = '{3, 7, 11, 15, 0, 0, 0, 0};
        send_row(0, 8, xs, 8'b1010_1010, ex);
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
